// File: rtl/timing_pkg.sv
// Shared definitions for the tick-qualified timing sequencer and its dwell counter.
package timing_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_fsm_t;

  localparam int DEFAULT_DWELL_WIDTH = 16;

  // Number of bits needed to index 'value' distinct items.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Up-counter measuring ticks spent in the current sequencer state.
module dwell_counter
  import timing_pkg::*;
#(
  parameter int DWELL_WIDTH = DEFAULT_DWELL_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   count_en,
  input  logic [DWELL_WIDTH-1:0] terminal,
  output logic                   at_terminal
);

  logic [DWELL_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + DWELL_WIDTH'(1);
    end
  end

  // >= so that a dwell shortened below the current count still terminates.
  assign at_terminal = (count >= terminal);

endmodule

// File: rtl/timing_sequencer.sv
// Parametrised state sequencer: each state is held for a programmable number of ticks.
// state   | meaning
// ST_IDLE | parked at index 0, counter cleared, waiting for start
// ST_RUN  | counting qualified ticks and stepping through the state indices
module timing_sequencer
  import timing_pkg::*;
#(
  parameter int NUM_STATES  = 4,
  parameter int STATE_WIDTH = clog2(NUM_STATES),
  parameter int DWELL_WIDTH = DEFAULT_DWELL_WIDTH,
  parameter bit AUTO_START  = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              tick,
  input  logic                              enable,
  input  logic                              one_shot,
  input  logic                              start,
  input  logic [NUM_STATES*DWELL_WIDTH-1:0] dwell,
  output logic [STATE_WIDTH-1:0]            state,
  output logic                              initial_state,
  output logic                              state_change,
  output logic                              busy,
  output logic                              done
);

  localparam logic [STATE_WIDTH-1:0] LAST_STATE = STATE_WIDTH'(NUM_STATES - 1);
  localparam seq_fsm_t RESET_FSM = AUTO_START ? ST_RUN : ST_IDLE;

  seq_fsm_t               fsm;
  seq_fsm_t               fsm_next;
  logic [STATE_WIDTH-1:0] state_next;
  logic                   initial_next;
  logic                   change_next;
  logic                   done_next;
  logic [DWELL_WIDTH-1:0] cur_dwell;
  logic [DWELL_WIDTH-1:0] terminal;
  logic                   qualified;
  logic                   at_terminal;
  logic                   advance;

  always_comb begin
    cur_dwell = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (state == STATE_WIDTH'(i)) begin
        cur_dwell = dwell[i*DWELL_WIDTH +: DWELL_WIDTH];
      end
    end
  end

  // A programmed dwell of zero behaves as a dwell of one tick.
  assign terminal  = (cur_dwell == '0) ? '0 : cur_dwell - DWELL_WIDTH'(1);
  assign qualified = (fsm == ST_RUN) && tick && enable;
  assign advance   = qualified && at_terminal;

  dwell_counter #(
    .DWELL_WIDTH (DWELL_WIDTH)
  ) u_dwell_counter (
    .clk         (clk),
    .reset       (reset),
    .clear       (advance || (fsm == ST_IDLE)),
    .count_en    (qualified),
    .terminal    (terminal),
    .at_terminal (at_terminal)
  );

  always_comb begin
    fsm_next     = fsm;
    state_next   = state;
    initial_next = 1'b0;
    change_next  = 1'b0;
    done_next    = 1'b0;
    case (fsm)
      ST_IDLE: begin
        state_next = '0;
        if (start) begin
          fsm_next     = ST_RUN;
          initial_next = 1'b1;
          change_next  = 1'b1;
        end
      end
      ST_RUN: begin
        if (advance) begin
          if (state != LAST_STATE) begin
            state_next  = state + STATE_WIDTH'(1);
            change_next = 1'b1;
          end else if (one_shot) begin
            fsm_next   = ST_IDLE;
            state_next = '0;
            done_next  = 1'b1;
          end else begin
            state_next   = '0;
            initial_next = 1'b1;
            change_next  = 1'b1;
          end
        end
      end
      default: begin
        fsm_next   = ST_IDLE;
        state_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm           <= RESET_FSM;
      state         <= '0;
      initial_state <= 1'b0;
      state_change  <= 1'b0;
      done          <= 1'b0;
    end else begin
      fsm           <= fsm_next;
      state         <= state_next;
      initial_state <= initial_next;
      state_change  <= change_next;
      done          <= done_next;
    end
  end

  assign busy = (fsm == ST_RUN);

endmodule

// File: doc/timing_sequencer.md
Name: timing_sequencer

Overview:
- Parametrised successor to the fixed four-state sequencer.
- Steps through NUM_STATES states, each held for a programmable number of tick pulses.
- Runs from the system clock, qualified by a one-cycle tick enable from the slow clock pulse generator, rather than being clocked by the pulse itself.
- Supports continuous (wrap-around) and one-shot modes, pause, and an entry marker for state 0 that drives the POP timing chain.

Parameters:
- NUM_STATES, 4, number of sequence states (2..16).
- STATE_WIDTH, 2, width of the state index; must satisfy 2**STATE_WIDTH >= NUM_STATES.
- DWELL_WIDTH, 16, width of each per-state dwell count.
- AUTO_START, 1, when 1 the sequencer leaves reset running in continuous mode without a start pulse.

Ports:
- clk  in  1  system clock (2.5 MHz); all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-clk-wide enable pulse; dwell counting advances only on tick.
- enable  in  1  1 = count, 0 = pause (state and count frozen).
- one_shot  in  1  0 = wrap after last state; 1 = stop after last state.
- start  in  1  one-clk pulse; launches a sequence from state 0 when idle.
- dwell  in  NUM_STATES*DWELL_WIDTH  dwell for state i is at bits [i*DWELL_WIDTH +: DWELL_WIDTH].
- state  out  STATE_WIDTH  current state index.
- initial_state  out  1  high for one clk on entry to state 0.
- state_change  out  1  high for one clk on every state entry.
- busy  out  1  high while in RUN.
- done  out  1  high for one clk when a one-shot sequence completes.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - state = 0, internal dwell counter = 0, initial_state = 0, state_change = 0, done = 0.
  - busy = AUTO_START; the FSM goes to RUN if AUTO_START = 1, else IDLE.
  - No entry pulse is issued on reset release.
- Control FSM (states IDLE, RUN):
  - IDLE: state holds 0 and the counter holds 0.
  - IDLE -> RUN on start = 1. On that clk, initial_state = 1 and state_change = 1 on the next edge.
  - start while in RUN is ignored.
  - RUN: the counter increments on a clk where tick = 1 and enable = 1.
  - Let D = dwell[state], with D = 0 treated as 1.
  - When tick = 1, enable = 1 and counter == D-1, the counter clears to 0 and state advances. The state_change pulse is registered on that same edge. Dwell in each state is therefore exactly D ticks.
- Advance rules:
  - state < NUM_STATES-1: state increments.
  - state == NUM_STATES-1, one_shot = 0: wrap to 0 and assert initial_state with state_change.
  - state == NUM_STATES-1, one_shot = 1: go to IDLE, state = 0, done = 1 for one clk, no initial_state or state_change pulse.
- Pause and tick: enable = 0 freezes counter and state regardless of tick. tick with enable = 0 is lost and not queued.
- Dwell sampling: dwell is sampled live. A value changed mid-state takes effect at the next comparison.
  - If the new D-1 is below the current count, the state advances on the next qualified tick (compare uses >=).
- Mode sampling: one_shot is sampled only at the last-state advance.
- Reset mid-sequence: returns to the reset values on the next edge and overrides start and tick in the same cycle.
- Pulse outputs (initial_state, state_change, done) are registered, exactly one clk wide, and low by default.
- Latency: a state advance is visible on state one clk after the qualifying tick cycle.

Decomposition:
- Shared package timing_pkg:
  - FSM encoding constants (ST_IDLE = 1'b0, ST_RUN = 1'b1).
  - Default dwell width.
  - A clog2 function used to derive STATE_WIDTH.
- One natural sub-module, dwell_counter (parametrised on DWELL_WIDTH):
  - Inputs: clear, count enable, terminal value.
  - Output: terminal flag (count >= terminal).
  - The FSM and state index stay in the top.

Test Plan:
- Auto-start, continuous: AUTO_START = 1, dwell = {4,3,2,1} (states 3..0), tick every 10 clk, enable = 1.
  - Required: state sequence 0,1,2,3,0 with dwells 1,2,3,4 ticks.
  - Required: initial_state pulses every 10 ticks; state_change pulses exactly 4 per cycle.
- Zero dwell: dwell[2] = 0.
  - Required: state 2 lasts exactly 1 tick, with no stall or skip.
- One-shot: AUTO_START = 0, one_shot = 1, start pulse, dwell = all 2.
  - Required: busy high for 8 ticks, then done for 1 clk, state = 0, busy = 0.
  - Required: a second start restarts the sequence; a start during RUN is ignored.
- Pause: enable low for 50 clk mid-state 1, ticks continuing.
  - Required: state and counter frozen; on resume, the remaining dwell completes with no lost or extra advance.
- Reset mid-run: reset asserted in state 2 concurrent with a qualifying tick.
  - Required: next edge gives state = 0 and all pulses 0; busy = AUTO_START.
- Dwell shrink: dwell[1] changed from 10 to 3 while the counter is at 6.
  - Required: advance to state 2 on the next qualified tick.
